// File: rtl/ofm_writeback.sv
// ofm_writeback: unpacks systolic result tiles into per-word writes of the output feature map,
// dropping lanes past the right edge of each row.
module ofm_writeback #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int OFM_SIZE      = 104,
    parameter int NO_FILTER     = 32,
    parameter int ADDR_WIDTH    = 19
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  tile_valid,
    output logic                                  tile_ready,
    input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0] tile_data,
    output logic                                  mem_we,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [2*DATA_WIDTH-1:0]               mem_wdata,
    output logic                                  busy,
    output logic                                  done
);
    localparam int WW = 2 * DATA_WIDTH;
    localparam int T  = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int LW = $clog2(SYSTOLIC_SIZE + 1);
    localparam int CW = $clog2(T + 1);
    localparam int RW = $clog2(OFM_SIZE + 1);
    localparam int FW = $clog2(NO_FILTER + 1);

    typedef enum logic [1:0] {IDLE, WAIT_TILE, WRITE, DONE} state_t;

    state_t                           state_q;
    logic [CW-1:0]                    col_q;
    logic [RW-1:0]                    row_q;
    logic [FW-1:0]                    fil_q;
    logic [SYSTOLIC_SIZE*WW-1:0]      tile_q;
    logic [LW-1:0]                    n_q, lane_q, n_d;
    logic [ADDR_WIDTH-1:0]            addr_q, mem_addr_q;
    logic [WW-1:0]                    mem_wdata_q;
    logic                             tile_ready_q, mem_we_q, busy_q, done_q;
    logic                             last_col, last_row, last_fil;
    int                               rem;

    always_comb begin
        rem      = OFM_SIZE - int'(col_q) * SYSTOLIC_SIZE;
        n_d      = (rem > SYSTOLIC_SIZE) ? LW'(SYSTOLIC_SIZE) : LW'(rem);
        last_col = col_q == CW'(T - 1);
        last_row = row_q == RW'(OFM_SIZE - 1);
        last_fil = fil_q == FW'(NO_FILTER - 1);
    end

    // Words land at consecutive addresses across the whole layer, so a running address suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            fil_q        <= '0;
            tile_q       <= '0;
            n_q          <= '0;
            lane_q       <= '0;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            tile_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= WAIT_TILE;
                        tile_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        col_q        <= '0;
                        row_q        <= '0;
                        fil_q        <= '0;
                        addr_q       <= '0;
                    end
                end
                WAIT_TILE: begin
                    if (tile_valid) begin
                        state_q      <= WRITE;
                        tile_ready_q <= 1'b0;
                        tile_q       <= tile_data >> WW;
                        n_q          <= n_d;
                        lane_q       <= LW'(1);
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= addr_q;
                        mem_wdata_q  <= tile_data[WW-1:0];
                        addr_q       <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                WRITE: begin
                    if (lane_q == n_q) begin
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        col_q       <= last_col ? '0 : col_q + CW'(1);
                        row_q       <= last_col ? (last_row ? '0 : row_q + RW'(1)) : row_q;
                        fil_q       <= (last_col && last_row) ? (last_fil ? '0 : fil_q + FW'(1)) : fil_q;
                        if (last_col && last_row && last_fil) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q      <= WAIT_TILE;
                            tile_ready_q <= 1'b1;
                        end
                    end else begin
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= tile_q[WW-1:0];
                        tile_q      <= tile_q >> WW;
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        lane_q      <= lane_q + LW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tile_ready = tile_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: doc/ofm_writeback.md
OFM_WRITEBACK -- requirements
Module: ofm_writeback

Interface
- REQ-001: Parameter SYSTOLIC_SIZE, default 16, is the number of result lanes per tile.
- REQ-002: Parameter DATA_WIDTH, default 8; each result word is 2*DATA_WIDTH bits wide.
- REQ-003: Parameter OFM_SIZE, default 104, is the output feature map height and width.
- REQ-004: Parameter NO_FILTER, default 32, is the number of output channels.
- REQ-005: Parameter ADDR_WIDTH, default 19, SHALL be at least clog2(NO_FILTER*OFM_SIZE*OFM_SIZE).
- REQ-006: clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
- REQ-007: rst, input, 1 bit: synchronous active-high reset.
- REQ-008: start, input, 1 bit: one-cycle pulse that begins a layer writeback.
- REQ-009: tile_valid, input, 1 bit: tile_data holds a tile.
- REQ-010: tile_ready, output, 1 bit: the block accepts a tile this cycle.
- REQ-011: tile_data, input, SYSTOLIC_SIZE*2*DATA_WIDTH bits: lane k occupies bits [16k+15:16k] for DATA_WIDTH=8.
- REQ-012: mem_we, output, 1 bit: write enable to the OFM DPRAM write port.
- REQ-013: mem_addr, output, ADDR_WIDTH bits: word address of the write.
- REQ-014: mem_wdata, output, 2*DATA_WIDTH bits: word to write.
- REQ-015: busy, output, 1 bit: high from the cycle after start until done.
- REQ-016: done, output, 1 bit: one-cycle pulse after the last word is written.

Function
- REQ-017: Tiles SHALL arrive in order: filter outermost, then row 0..OFM_SIZE-1, then column tile 0..T-1 innermost, with T = ceil(OFM_SIZE/SYSTOLIC_SIZE).
- REQ-018: Tile t of a row SHALL cover columns t*SYSTOLIC_SIZE onward; its valid lane count n = min(SYSTOLIC_SIZE, OFM_SIZE - t*SYSTOLIC_SIZE).
- REQ-019: Lanes at index n and above SHALL be discarded and never written.
- REQ-020: Lane k of tile (f,r,t) SHALL be written to address f*OFM_SIZE*OFM_SIZE + r*OFM_SIZE + t*SYSTOLIC_SIZE + k.
- REQ-021: FSM states SHALL be IDLE, WAIT_TILE, WRITE and DONE.
- REQ-022: IDLE goes to WAIT_TILE on start; tile_valid is ignored in IDLE.
- REQ-023: WAIT_TILE: tile_ready=1; on tile_valid&&tile_ready the block captures tile_data, computes n, and goes to WRITE.
- REQ-024: WRITE: tile_ready=0; one word per cycle, lane 0 first, with mem_we=1; the first write occurs in the cycle after the handshake.
- REQ-025: WRITE takes exactly n cycles.
- REQ-026: After the last lane of a non-final tile, WRITE goes to WAIT_TILE, so tile_ready re-asserts the cycle after the final write.
- REQ-027: After the last lane of tile (NO_FILTER-1, OFM_SIZE-1, T-1), WRITE goes to DONE.
- REQ-028: DONE asserts done for exactly one cycle, deasserts busy, and returns to IDLE.
- REQ-029: The column, row and filter counters SHALL wrap as follows: column tile wraps to 0 and increments row; row wraps to 0 and increments filter.
- REQ-030: A start pulse while busy=1 SHALL be ignored, with no counter change.
- REQ-031: A start pulse in the same cycle as DONE SHALL be ignored; a new layer needs start while in IDLE.
- REQ-032: mem_wdata SHALL be the captured lane unmodified, with no saturation or sign handling.
- REQ-033: mem_addr and mem_wdata SHALL be 0 whenever mem_we=0.
- REQ-034: The total number of writes per layer SHALL be exactly NO_FILTER*OFM_SIZE*OFM_SIZE, with no address written twice.

Reset
- REQ-035: While rst=1 at a clock edge, the FSM SHALL go to IDLE and all counters and the captured tile SHALL clear.
- REQ-036: While rst=1 at a clock edge, tile_ready, mem_we, mem_addr, mem_wdata, busy and done SHALL all be 0 from the following cycle.
- REQ-037: A reset mid-tile SHALL abort the remaining lanes of that tile with no further writes; the next start restarts at address 0.

Verification (SYSTOLIC_SIZE=16, OFM_SIZE=20, NO_FILTER=2, so T=2)
- REQ-038: Full layer, tile_valid always high -> 80 handshakes, 800 writes at addresses 0..799 each exactly once, done one cycle after the write to address 799.
- REQ-039: Tile (0,0,1) with lanes 0..15 = 0x0100+k -> writes of 0x0100..0x0103 to addresses 16..19 only, over 4 cycles, then tile_ready=1.
- REQ-040: Tile (1,3,0) with lane k = 0xFF00+k -> addresses 460..475 receive 0xFF00..0xFF0F on consecutive cycles, with the first write one cycle after the handshake.
- REQ-041: Random tile_valid gaps -> data and address sequence identical to the gap-free run; no write occurs while in WAIT_TILE.
- REQ-042: rst asserted during the 5th write of a tile -> no writes after reset; start then gives a first write at address 0.
- REQ-043: start pulsed while busy, and tile_valid pulsed while in IDLE -> no effect on the counters or on any write.
